vga_text_window: RTL and testbench

VGA_TEXT_WINDOW -- requirements
Module: vga_text_window

---
 rtl/vga_text_window.sv | 149 ++++++++++++++
 tb/tb_vga_text_window.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_window.sv
// Character-cell text window overlay for a VGA raster: maps the current pixel to a
// text-buffer address, renders one cycle later, and adds a blinking cursor plus per-frame scrolling.
`ifndef WHITE
`define WHITE 3'b111
`endif
`ifndef BLACK
`define BLACK 3'b000
`endif

module vga_text_window #(
    parameter int         LINE         = 0,
    parameter int         COL          = 0,
    parameter int         PZOOM        = 0,
    parameter logic [2:0] PCOLOR       = `WHITE,
    parameter int         WIDTH        = 16,
    parameter int         HEIGHT       = 4,
    parameter int         OFFSET       = 0,
    parameter int         AW           = 12,
    parameter int         BLINK_FRAMES = 30,
    parameter logic       CN2D         = 1'b0
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [2:0]    color,
    output logic [1:0]    zoom,
    output logic          n2d,
    input  logic          cursor_en,
    input  logic [15:0]   cursor_pos,
    input  logic          scroll_req,
    output logic          scroll_ack
);

    localparam int SH = 3 + PZOOM;
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } scroll_state_t;

    scroll_state_t state, state_next;

    logic [9:0]    cx, cy;
    logic [11:0]   dx, dy;
    logic          active0;
    logic [7:0]    rel_x, rel_y;
    logic [8:0]    row_sum, phys_row;
    logic [7:0]    scroll_row, scroll_row_next;
    logic          frame_start;
    logic          act_q;
    logic [7:0]    relx_q, rely_q;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          hit;

    assign cx = x >> SH;
    assign cy = y >> SH;

    // A cell left of / above the window makes the 12-bit difference wrap, setting bit 11.
    assign dx = {2'b00, cx} - 12'(COL);
    assign dy = {2'b00, cy} - 12'(LINE);
    assign active0 = !dx[11] && (dx < 12'(WIDTH)) && !dy[11] && (dy < 12'(HEIGHT));
    assign rel_x = dx[7:0];
    assign rel_y = dy[7:0];

    // rel_y and scroll_row are both below HEIGHT, so one subtract performs the modulo.
    assign row_sum  = {1'b0, rel_y} + {1'b0, scroll_row};
    assign phys_row = (row_sum >= 9'(HEIGHT)) ? (row_sum - 9'(HEIGHT)) : row_sum;
    assign addr = active0 ? (AW'(OFFSET) + AW'(phys_row) * AW'(WIDTH) + AW'(rel_x)) : '0;

    assign frame_start = (x == 10'd0) && (y == 10'd0);

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            act_q  <= 1'b0;
            relx_q <= '0;
            rely_q <= '0;
        end else begin
            act_q  <= active0;
            relx_q <= rel_x;
            rely_q <= rel_y;
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            scroll_row <= '0;
        end else begin
            state      <= state_next;
            scroll_row <= scroll_row_next;
        end
    end

    // Scrolling only advances on frame_start so a frame never shows two offsets.
    always_comb begin
        state_next      = state;
        scroll_row_next = scroll_row;
        case (state)
            S_IDLE: begin
                if (frame_start && scroll_req) begin
                    state_next      = S_ACK;
                    scroll_row_next = (scroll_row == 8'(HEIGHT - 1)) ? 8'd0 : (scroll_row + 8'd1);
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign scroll_ack = (state == S_ACK);

    assign hit = act_q && cursor_en && blink_on
              && (cursor_pos[15:8] == rely_q) && (cursor_pos[7:0] == relx_q)
              && (cursor_pos[15:8] < 8'(HEIGHT)) && (cursor_pos[7:0] < 8'(WIDTH));

    always_comb begin
        dout  = 8'd0;
        n2d   = 1'b0;
        zoom  = 2'd0;
        color = `BLACK;
        if (act_q) begin
            dout  = din;
            n2d   = CN2D;
            zoom  = 2'(PZOOM);
            color = hit ? ~PCOLOR : PCOLOR;
        end
    end

endmodule

// File: tb/tb_vga_text_window.sv
// Directed bench for vga_text_window: address mapping, window edges, cursor blink,
// scrolling (including a one-row window) and reset during a scroll acknowledge.
`ifndef WHITE
`define WHITE 3'b111
`endif
`ifndef BLACK
`define BLACK 3'b000
`endif

module tb_vga_text_window;

    localparam logic [2:0] PC_A  = 3'b010;
    localparam logic [2:0] INV_A = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic [7:0]  din;
    logic        cursor_en;
    logic [15:0] cursor_pos;
    logic        scroll_req;

    logic [11:0] addr_a, addr_b, addr_c;
    logic [7:0]  dout_a, dout_b, dout_c;
    logic [2:0]  color_a, color_b, color_c;
    logic [1:0]  zoom_a, zoom_b, zoom_c;
    logic        n2d_a, n2d_b, n2d_c;
    logic        ack_a, ack_b, ack_c;

    int n_cmp = 0;
    int n_mis = 0;
    int sr;

    always #5 clk = ~clk;

    vga_text_window #(.LINE(2), .COL(4), .PZOOM(0), .PCOLOR(PC_A), .WIDTH(8), .HEIGHT(4),
                      .OFFSET('h10), .AW(12), .BLINK_FRAMES(2), .CN2D(1'b1)) u_a (
        .px_clk(clk), .reset(rst), .x(x), .y(y), .addr(addr_a), .din(din), .dout(dout_a),
        .color(color_a), .zoom(zoom_a), .n2d(n2d_a), .cursor_en(cursor_en),
        .cursor_pos(cursor_pos), .scroll_req(scroll_req), .scroll_ack(ack_a));

    vga_text_window #(.LINE(0), .COL(0), .PZOOM(1), .OFFSET('h20)) u_b (
        .px_clk(clk), .reset(rst), .x(x), .y(y), .addr(addr_b), .din(din), .dout(dout_b),
        .color(color_b), .zoom(zoom_b), .n2d(n2d_b), .cursor_en(cursor_en),
        .cursor_pos(cursor_pos), .scroll_req(scroll_req), .scroll_ack(ack_b));

    vga_text_window #(.LINE(2), .COL(4), .WIDTH(8), .HEIGHT(1), .OFFSET('h10)) u_c (
        .px_clk(clk), .reset(rst), .x(x), .y(y), .addr(addr_c), .din(din), .dout(dout_c),
        .color(color_c), .zoom(zoom_c), .n2d(n2d_c), .cursor_en(cursor_en),
        .cursor_pos(cursor_pos), .scroll_req(scroll_req), .scroll_ack(ack_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_xy(input int nx, input int ny);
        x = 10'(nx);
        y = 10'(ny);
        #1;
    endtask

    task automatic frame();
        x = 10'd0;
        y = 10'd0;
        step();
        x = 10'd100;
        y = 10'd100;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        x          = 10'd32;
        y          = 10'd16;
        din        = 8'h55;
        cursor_en  = 1'b0;
        cursor_pos = 16'h0000;
        scroll_req = 1'b0;
        #12;
        step();
        chk("rst_dout", 32'(dout_a), 32'h00);
        chk("rst_color", 32'(color_a), 32'(`BLACK));
        chk("rst_zoom", 32'(zoom_a), 32'd0);
        chk("rst_n2d", 32'(n2d_a), 32'd0);
        chk("rst_ack", 32'(ack_a), 32'd0);

        rst = 1'b0;
        set_xy(32, 16);
        chk("addr_origin", 32'(addr_a), 32'h010);
        din = 8'h41;
        step();
        chk("dout_origin", 32'(dout_a), 32'h41);
        chk("color_origin", 32'(color_a), 32'(PC_A));
        chk("zoom_origin", 32'(zoom_a), 32'd0);
        chk("n2d_origin", 32'(n2d_a), 32'd1);

        set_xy(95, 47);
        chk("addr_corner", 32'(addr_a), 32'h02F);
        set_xy(40, 47);
        chk("addr_5_5", 32'(addr_a), 32'h029);
        set_xy(96, 47);
        chk("addr_right_out", 32'(addr_a), 32'h000);
        step();
        chk("dout_right_out", 32'(dout_a), 32'h00);
        chk("color_right_out", 32'(color_a), 32'(`BLACK));
        chk("n2d_right_out", 32'(n2d_a), 32'd0);
        set_xy(31, 16);
        chk("addr_left_out", 32'(addr_a), 32'h000);
        set_xy(32, 15);
        chk("addr_top_out", 32'(addr_a), 32'h000);
        set_xy(32, 48);
        chk("addr_bottom_out", 32'(addr_a), 32'h000);

        set_xy(15, 15);
        chk("zoom1_addr0", 32'(addr_b), 32'h020);
        set_xy(16, 15);
        chk("zoom1_addr1", 32'(addr_b), 32'h021);
        step();
        chk("zoom1_zoom", 32'(zoom_b), 32'd1);
        chk("zoom1_color", 32'(color_b), 32'(`WHITE));
        chk("zoom1_dout", 32'(dout_b), 32'h41);

        // Cursor at row 1, col 2 -> pixel (48,24); two frames on, two frames off.
        cursor_en  = 1'b1;
        cursor_pos = 16'h0102;
        din        = 8'h7E;
        set_xy(48, 24); step();
        chk("cur_f0", 32'(color_a), 32'(INV_A));
        chk("cur_f0_dout", 32'(dout_a), 32'h7E);
        set_xy(56, 24); step();
        chk("cur_f0_neighbour", 32'(color_a), 32'(PC_A));
        frame();
        set_xy(48, 24); step();
        chk("cur_f1", 32'(color_a), 32'(INV_A));
        frame();
        set_xy(48, 24); step();
        chk("cur_f2", 32'(color_a), 32'(PC_A));
        frame();
        set_xy(48, 24); step();
        chk("cur_f3", 32'(color_a), 32'(PC_A));
        frame();
        set_xy(48, 24); step();
        chk("cur_f4", 32'(color_a), 32'(INV_A));
        cursor_pos = 16'h0902;
        step();
        chk("cur_row_oob", 32'(color_a), 32'(PC_A));
        cursor_pos = 16'h0102;
        cursor_en  = 1'b0;
        step();
        chk("cur_disabled", 32'(color_a), 32'(PC_A));

        // Request held outside frame_start must not scroll.
        scroll_req = 1'b1;
        set_xy(5, 5);
        step(); step();
        chk("req_no_fs_ack", 32'(ack_a), 32'd0);
        set_xy(32, 16);
        chk("req_no_fs_addr", 32'(addr_a), 32'h010);

        sr = 0;
        for (int k = 0; k < 4; k++) begin
            set_xy(32, 16);
            chk("scroll_addr", 32'(addr_a), 32'(16 + sr * 8));
            chk("scroll_h1_addr", 32'(addr_c), 32'h010);
            if (sr == 1) begin
                set_xy(32, 40);
                chk("scroll_wrap_addr", 32'(addr_a), 32'h010);
            end
            frame();
            sr = (sr + 1) % 4;
            chk("scroll_ack_hi", 32'(ack_a), 32'd1);
            chk("scroll_h1_ack_hi", 32'(ack_c), 32'd1);
            step();
            chk("scroll_ack_lo", 32'(ack_a), 32'd0);
            step();
            chk("scroll_ack_held_lo", 32'(ack_a), 32'd0);
        end
        set_xy(32, 16);
        chk("scroll_four_back", 32'(addr_a), 32'h010);

        // Two more scrolls: the second leaves scroll_row=2, blink_on=0, ack high.
        frame();
        step(); step();
        frame();
        chk("pre_rst_ack", 32'(ack_a), 32'd1);
        x   = 10'd32;
        y   = 10'd16;
        rst = 1'b1;
        #1;
        chk("async_rst_ack", 32'(ack_a), 32'd0);
        chk("async_rst_color", 32'(color_a), 32'(`BLACK));
        step();
        chk("in_rst_dout", 32'(dout_a), 32'h00);
        chk("in_rst_color", 32'(color_a), 32'(`BLACK));
        chk("in_rst_zoom", 32'(zoom_a), 32'd0);
        chk("in_rst_n2d", 32'(n2d_a), 32'd0);

        rst        = 1'b0;
        scroll_req = 1'b0;
        cursor_en  = 1'b1;
        cursor_pos = 16'h0000;
        set_xy(32, 16);
        chk("post_rst_addr", 32'(addr_a), 32'h010);
        step();
        chk("post_rst_blink", 32'(color_a), 32'(INV_A));
        cursor_en  = 1'b0;
        scroll_req = 1'b1;
        frame();
        chk("post_rst_ack", 32'(ack_a), 32'd1);
        chk("post_rst_h1_ack", 32'(ack_c), 32'd1);
        scroll_req = 1'b0;
        step();
        set_xy(32, 16);
        chk("post_rst_scroll_addr", 32'(addr_a), 32'h018);
        chk("post_rst_h1_addr", 32'(addr_c), 32'h010);
        frame();
        chk("no_req_ack", 32'(ack_a), 32'd0);
        set_xy(32, 16);
        chk("no_req_addr", 32'(addr_a), 32'h018);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
